// File: rtl/hps_frame_ctrl.sv
// HPS frame controller: writes one frame of DFT magnitudes into the magnitude RAM,
// then scans k = 1..SCAN_LAST and multiplies X[k] * X[k>>1] * X[k/3] to find the
// bin with the largest product (pitch estimate).
//
//   state | meaning
//   IDLE  | accepting magnitude beats into the RAM
//   SCAN  | three reads per bin (k, k>>1, k/3), product pipeline running
//   DRAIN | no read; final product of the last bin is compared
//   DONE  | peak_valid pulse, peak_k/peak_prod presented
module hps_frame_ctrl #(
   parameter int K_WIDTH   = 12,
   parameter int MAG_WIDTH = 16,
   parameter int SCAN_LAST = 2047
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     mag_valid,
   input  logic                     mag_last,
   input  logic [MAG_WIDTH-1:0]     mag_data,
   output logic                     ram_we,
   output logic [K_WIDTH-1:0]       ram_waddr,
   output logic [MAG_WIDTH-1:0]     ram_wdata,
   output logic                     ram_re,
   output logic [K_WIDTH-1:0]       ram_raddr,
   input  logic [MAG_WIDTH-1:0]     ram_rdata,
   output logic                     busy,
   output logic                     peak_valid,
   output logic [K_WIDTH-1:0]       peak_k,
   output logic [3*MAG_WIDTH-1:0]   peak_prod,
   output logic                     frame_dropped
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SCAN  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int                 PW     = 3 * MAG_WIDTH;
   localparam int                 AW     = 2 * MAG_WIDTH;
   localparam logic [K_WIDTH-1:0] K_ONE  = K_WIDTH'(1);
   localparam logic [K_WIDTH-1:0] K_LAST = K_WIDTH'(SCAN_LAST);

   logic [1:0]           state, state_nxt;
   logic [K_WIDTH-1:0]   wcnt;
   logic                 skip;
   logic [K_WIDTH-1:0]   k, q3, ab_k, best_k;
   logic [1:0]           phase, res;
   logic [MAG_WIDTH-1:0] a;
   logic [AW-1:0]        ab;
   logic [PW-1:0]        prod, best_prod;
   logic                 beat_ok, beat_drop, frame_in, scan_end, cmp_en, take;

   // A beat is stored only in IDLE outside a skipped frame; anything else is discarded.
   assign beat_ok   = mag_valid && !skip && (state == S_IDLE);
   assign beat_drop = mag_valid && (skip || (state != S_IDLE));
   assign frame_in  = beat_ok && mag_last;
   assign scan_end  = (state == S_SCAN) && (phase == 2'd2) && (k == K_LAST);

   assign ram_we        = beat_ok;
   assign ram_waddr     = beat_ok ? wcnt : '0;
   assign ram_wdata     = beat_ok ? mag_data : '0;
   assign ram_re        = (state == S_SCAN);
   assign busy          = (state != S_IDLE);
   assign peak_valid    = (state == S_DONE);
   assign frame_dropped = beat_drop && mag_last;

   // The third operand arrives in the p0 of the next bin (or DRAIN for the last bin).
   assign prod   = PW'(ab) * PW'(ram_rdata);
   assign cmp_en = ((state == S_SCAN) && (phase == 2'd0) && (k != K_ONE)) || (state == S_DRAIN);
   assign take   = cmp_en && ((ab_k == K_ONE) || (prod > best_prod));

   // Read address per phase: X[k], X[k>>1], X[k/3].
   always_comb begin
      ram_raddr = '0;
      if (state == S_SCAN) begin
         case (phase)
            2'd0:    ram_raddr = k;
            2'd1:    ram_raddr = k >> 1;
            default: ram_raddr = q3;
         endcase
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (frame_in) state_nxt = S_SCAN;
         S_SCAN:  if (scan_end) state_nxt = S_DRAIN;
         S_DRAIN: state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register, write counter and the skip flag for frames that start mid-scan.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= S_IDLE;
         wcnt  <= '0;
         skip  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (beat_ok)
            wcnt <= mag_last ? '0 : wcnt + K_ONE;
         if (beat_drop)
            skip <= !mag_last;
      end
   end

   // Scan sequencing: bin index, phase, and k/3 tracked by a mod-3 residue.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         k     <= K_ONE;
         phase <= 2'd0;
         q3    <= '0;
         res   <= 2'd1;
      end else if (frame_in) begin
         k     <= K_ONE;
         phase <= 2'd0;
         q3    <= '0;
         res   <= 2'd1;
      end else if (state == S_SCAN) begin
         if (phase == 2'd2) begin
            phase <= 2'd0;
            k     <= k + K_ONE;
            if (res == 2'd2) begin
               res <= 2'd0;
               q3  <= q3 + K_ONE;
            end else begin
               res <= res + 2'd1;
            end
         end else begin
            phase <= phase + 2'd1;
         end
      end
   end

   // Product pipeline: first operand in p1, partial product in p2.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         a    <= '0;
         ab   <= '0;
         ab_k <= '0;
      end else if (state == S_SCAN) begin
         if (phase == 2'd1)
            a <= ram_rdata;
         if (phase == 2'd2) begin
            ab   <= AW'(a) * AW'(ram_rdata);
            ab_k <= k;
         end
      end
   end

   // Running peak; ties keep the earlier (lower) bin.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         best_k    <= '0;
         best_prod <= '0;
      end else if (take) begin
         best_k    <= ab_k;
         best_prod <= prod;
      end
   end

   // Result registers, loaded as DRAIN finishes so DONE presents the final answer.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         peak_k    <= '0;
         peak_prod <= '0;
      end else if (state == S_DRAIN) begin
         peak_k    <= take ? ab_k : best_k;
         peak_prod <= take ? prod : best_prod;
      end
   end

endmodule

// File: tb/tb_hps_frame_ctrl.sv
// Bench for hps_frame_ctrl: a small instance (16 bins, scan 1..7) for directed and
// random frames, plus a default-size instance for the full-length all-zero frame.
module tb_hps_frame_ctrl;

   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   int n_assert = 0;
   int n_fail   = 0;

   // Small instance signals
   logic        mag_valid, mag_last;
   logic [15:0] mag_data;
   logic        s_we, s_re, s_busy, s_pv, s_fd;
   logic [3:0]  s_waddr, s_raddr, s_pk;
   logic [15:0] s_wdata, s_rdata;
   logic [47:0] s_pp;

   // Default instance signals
   logic        d_valid, d_last;
   logic [15:0] d_data;
   logic        d_we, d_re, d_busy, d_pv, d_fd;
   logic [11:0] d_waddr, d_raddr, d_pk;
   logic [15:0] d_wdata, d_rdata;
   logic [47:0] d_pp;

   hps_frame_ctrl #(.K_WIDTH(4), .MAG_WIDTH(16), .SCAN_LAST(7)) dut_s (
      .clock(clock), .reset_n(reset_n),
      .mag_valid(mag_valid), .mag_last(mag_last), .mag_data(mag_data),
      .ram_we(s_we), .ram_waddr(s_waddr), .ram_wdata(s_wdata),
      .ram_re(s_re), .ram_raddr(s_raddr), .ram_rdata(s_rdata),
      .busy(s_busy), .peak_valid(s_pv), .peak_k(s_pk), .peak_prod(s_pp),
      .frame_dropped(s_fd)
   );

   hps_frame_ctrl dut_d (
      .clock(clock), .reset_n(reset_n),
      .mag_valid(d_valid), .mag_last(d_last), .mag_data(d_data),
      .ram_we(d_we), .ram_waddr(d_waddr), .ram_wdata(d_wdata),
      .ram_re(d_re), .ram_raddr(d_raddr), .ram_rdata(d_rdata),
      .busy(d_busy), .peak_valid(d_pv), .peak_k(d_pk), .peak_prod(d_pp),
      .frame_dropped(d_fd)
   );

   // Simple dual-port RAM models with one-cycle read latency
   logic [15:0] mem_s [16];
   logic [15:0] mem_d [4096];
   always @(posedge clock) begin
      if (s_we) mem_s[s_waddr] <= s_wdata;
      if (s_re) s_rdata <= mem_s[s_raddr];
      if (d_we) mem_d[d_waddr] <= d_wdata;
      if (d_re) d_rdata <= mem_d[d_raddr];
   end

   // Read-address trace of the small instance
   int rq[$];
   always @(negedge clock) if (s_re) rq.push_back(int'(s_raddr));

   logic [15:0] xs [16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: highest X[k]*X[k/2]*X[k/3] over k=1..7, first occurrence wins ties
   function automatic void hps_model(input logic [15:0] x [16], output int pk,
                                     output longint unsigned pp);
      longint unsigned p;
      pp = 0;
      pk = 0;
      for (int kk = 1; kk <= 7; kk++) begin
         p = x[kk];
         p = p * x[kk / 2];
         p = p * x[kk / 3];
         if (kk == 1 || p > pp) begin
            pp = p;
            pk = kk;
         end
      end
   endfunction

   task automatic send_beats(input string tag);
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         mag_valid = 1'b1;
         mag_last  = (i == 15);
         mag_data  = xs[i];
         #1;
         chk({tag, "_we"}, 64'(s_we), 64'(1));
         chk({tag, "_waddr"}, 64'(s_waddr), 64'(i));
      end
   endtask

   task automatic wait_peak(output int n);
      n = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clock);
         if (c == 0) begin
            mag_valid = 1'b0;
            mag_last  = 1'b0;
            mag_data  = '0;
         end
         n++;
         if (s_pv) break;
      end
   endtask

   task automatic run_frame(input string tag);
      int n;
      int pk;
      longint unsigned pp;
      hps_model(xs, pk, pp);
      rq.delete();
      send_beats(tag);
      wait_peak(n);
      chk({tag, "_latency"}, 64'(n), 64'(23));
      chk({tag, "_peak_k"}, 64'(s_pk), 64'(pk));
      chk({tag, "_peak_prod"}, 64'(s_pp), 64'(pp));
      chk({tag, "_nreads"}, 64'(rq.size()), 64'(21));
      for (int i = 0; i < 21 && i < rq.size(); i++) begin
         int kk, e;
         kk = i / 3 + 1;
         e  = (i % 3 == 0) ? kk : (i % 3 == 1) ? kk / 2 : kk / 3;
         chk($sformatf("%s_raddr%0d", tag, i), 64'(rq[i]), 64'(e));
      end
   endtask

   initial begin
      int n, pk, pv_at, we_cnt, fd_cnt;
      logic pv_seen, fd_last;
      logic [3:0] cap_k;
      logic [47:0] cap_p;
      longint unsigned pp;

      reset_n = 1'b0;
      mag_valid = 0; mag_last = 0; mag_data = '0;
      d_valid = 0; d_last = 0; d_data = '0;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("rst_we", 64'(s_we), 64'(0));
      chk("rst_re", 64'(s_re), 64'(0));
      chk("rst_busy", 64'(s_busy), 64'(0));
      chk("rst_pv", 64'(s_pv), 64'(0));
      chk("rst_pk", 64'(s_pk), 64'(0));
      chk("rst_pp", 64'(s_pp), 64'(0));
      chk("rst_d_busy", 64'(d_busy), 64'(0));

      // All ones: every product 1, first bin wins
      for (int i = 0; i < 16; i++) xs[i] = 16'd1;
      run_frame("ones");
      chk("ones_k_const", 64'(s_pk), 64'(1));
      chk("ones_p_const", 64'(s_pp), 64'(1));

      // X[2]=X[3]=X[6]=10: bin 6 gives 1000
      xs[2] = 16'd10; xs[3] = 16'd10; xs[6] = 16'd10;
      run_frame("tens");
      chk("tens_k_const", 64'(s_pk), 64'(6));
      chk("tens_p_const", 64'(s_pp), 64'(1000));

      // Strictly larger later bin wins
      for (int i = 0; i < 16; i++) xs[i] = 16'd1;
      xs[1] = 16'd2; xs[2] = 16'd5; xs[4] = 16'd5;
      run_frame("gt");
      chk("gt_k_const", 64'(s_pk), 64'(4));

      // Bins 2, 4 and 5 all give 10: lowest bin kept
      xs[4] = 16'd1;
      run_frame("tie");
      chk("tie_k_const", 64'(s_pk), 64'(2));
      chk("tie_p_const", 64'(s_pp), 64'(10));

      // Random frames, narrow range (ties likely) and full range
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 16; i++)
            xs[i] = 16'($urandom_range(0, (r < 2) ? 3 : 65535));
         run_frame($sformatf("rnd%0d", r));
      end

      // Frame arriving late in a scan is dropped as a whole
      for (int i = 0; i < 16; i++) xs[i] = 16'($urandom_range(0, 255));
      hps_model(xs, pk, pp);
      send_beats("drop_a");
      pv_seen = 1'b0;
      for (int c = 0; c < 17; c++) begin
         @(negedge clock);
         if (c == 0) begin mag_valid = 0; mag_last = 0; end
         pv_seen |= s_pv;
      end
      pv_at = -1; we_cnt = 0; fd_cnt = 0; fd_last = 1'b0; cap_k = '0; cap_p = '0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         mag_valid = 1'b1;
         mag_last  = (i == 15);
         mag_data  = 16'($urandom);
         #1;
         we_cnt += int'(s_we);
         fd_cnt += int'(s_fd);
         if (s_pv) begin pv_at = i; cap_k = s_pk; cap_p = s_pp; end
         if (i == 15) fd_last = s_fd;
      end
      chk("drop_pv_early", 64'(pv_seen), 64'(0));
      chk("drop_pv_at", 64'(pv_at), 64'(5));
      chk("drop_peak_k", 64'(cap_k), 64'(pk));
      chk("drop_peak_p", 64'(cap_p), 64'(pp));
      chk("drop_we_cnt", 64'(we_cnt), 64'(0));
      chk("drop_fd_cnt", 64'(fd_cnt), 64'(1));
      chk("drop_fd_last", 64'(fd_last), 64'(1));
      for (int i = 0; i < 16; i++) xs[i] = 16'($urandom_range(0, 1023));
      run_frame("after_drop");

      // Reset in the middle of a scan abandons it
      for (int i = 0; i < 16; i++) xs[i] = 16'd7;
      send_beats("rst_a");
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (c == 0) begin mag_valid = 0; mag_last = 0; end
      end
      chk("rst_mid_busy", 64'(s_busy), 64'(1));
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("rstm_re", 64'(s_re), 64'(0));
      chk("rstm_raddr", 64'(s_raddr), 64'(0));
      chk("rstm_we", 64'(s_we), 64'(0));
      chk("rstm_waddr", 64'(s_waddr), 64'(0));
      chk("rstm_busy", 64'(s_busy), 64'(0));
      chk("rstm_pv", 64'(s_pv), 64'(0));
      chk("rstm_pk", 64'(s_pk), 64'(0));
      chk("rstm_pp", 64'(s_pp), 64'(0));
      chk("rstm_fd", 64'(s_fd), 64'(0));
      pv_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         pv_seen |= s_pv;
      end
      chk("rstm_no_pv", 64'(pv_seen), 64'(0));
      for (int i = 0; i < 16; i++) xs[i] = 16'($urandom);
      run_frame("post_rst");

      // Default size: 4096 zero beats
      for (int i = 0; i < 4096; i++) begin
         @(negedge clock);
         d_valid = 1'b1;
         d_last  = (i == 4095);
         d_data  = '0;
      end
      n = 0;
      for (int c = 0; c < 7000; c++) begin
         @(negedge clock);
         if (c == 0) begin d_valid = 0; d_last = 0; end
         n++;
         if (d_pv) break;
      end
      chk("dflt_latency", 64'(n), 64'(6143));
      chk("dflt_peak_k", 64'(d_pk), 64'(1));
      chk("dflt_peak_p", 64'(d_pp), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
